// File: rtl/spike_line_window_buffer_if.sv
// Line-in / window-out bundle for the spike line window buffer.
// Master drives configuration, lines and ready; slave returns windows and status.
interface spike_line_window_buffer_if #(
    parameter int W = 128
);
    logic          code_valid;
    logic [15:0]   i_rows;
    logic          i_line_valid;
    logic [W-1:0]  i_line_data;
    logic          i_win_ready;
    logic          o_win_valid;
    logic [W-1:0]  o_win_top;
    logic [W-1:0]  o_win_mid;
    logic [W-1:0]  o_win_bot;
    logic [15:0]   o_win_row;
    logic          o_frame_done;
    logic          o_overflow;
    logic          o_cfg_err;

    modport master (
        output code_valid, i_rows, i_line_valid, i_line_data, i_win_ready,
        input  o_win_valid, o_win_top, o_win_mid, o_win_bot, o_win_row,
        input  o_frame_done, o_overflow, o_cfg_err
    );

    modport slave (
        input  code_valid, i_rows, i_line_valid, i_line_data, i_win_ready,
        output o_win_valid, o_win_top, o_win_mid, o_win_bot, o_win_row,
        output o_frame_done, o_overflow, o_cfg_err
    );
endinterface

// File: rtl/spike_line_window_buffer.sv
// Circular line buffer presenting 3-line vertical windows of a spike frame.
// Define SPK_LINE_PAD_EN for zero-padded top/bottom windows (i_rows windows).
module spike_line_window_buffer #(
    parameter int IMG_WIDTH  = 32,
    parameter int TIME_STEPS = 4,
    parameter int DEPTH      = 4
) (
    input logic                  s_clk,
    input logic                  s_rst,
    spike_line_window_buffer_if.slave bus
);
    localparam int W  = IMG_WIDTH * TIME_STEPS;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);
`ifdef SPK_LINE_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif
    localparam logic [15:0] MIN_ROWS = PAD ? 16'd2 : 16'd3;

    typedef logic [PW-1:0] ptr_t;

    logic [W-1:0]  mem [DEPTH];
    ptr_t          wr_ptr;
    ptr_t          fr_ptr;
    ptr_t          p1;
    ptr_t          p2;
    logic [OW-1:0] occ;
    logic [OW-1:0] need;
    logic [15:0]   rows_q;
    logic [15:0]   lines_in;
    logic [15:0]   win_row;
    logic [15:0]   last_row;
    logic          active;
    logic          cfg_err;
    logic          overflow;
    logic          frame_done;
    logic          first_w;
    logic          edge_w;
    logic          win_valid;
    logic          hs;
    logic          last;
    logic          free;
    logic          accept;
    logic          wr_en;
    logic          drop;

    function automatic ptr_t inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    always_comb begin
        p1       = inc(fr_ptr);
        p2       = inc(p1);
        last_row = PAD ? rows_q - 16'd1 : rows_q - 16'd3;
        first_w  = PAD && (win_row == 16'd0);
        edge_w   = PAD && (win_row == last_row);
        // Padded edge windows need only two real lines resident.
        need     = (first_w || edge_w) ? OW'(2) : OW'(3);
        win_valid = active && (occ >= need);
        hs       = win_valid && bus.i_win_ready;
        last     = (win_row == last_row);
        free     = hs && !first_w;
        accept   = active && bus.i_line_valid && (lines_in < rows_q);
        wr_en    = accept && ((occ != OW'(DEPTH)) || free);
        drop     = accept && !wr_en;
    end

    always_comb begin
        bus.o_win_top = '0;
        bus.o_win_mid = '0;
        bus.o_win_bot = '0;
        if (win_valid) begin
            if (first_w) begin
                bus.o_win_mid = mem[fr_ptr];
                bus.o_win_bot = mem[p1];
            end else if (edge_w) begin
                bus.o_win_top = mem[fr_ptr];
                bus.o_win_mid = mem[p1];
            end else begin
                bus.o_win_top = mem[fr_ptr];
                bus.o_win_mid = mem[p1];
                bus.o_win_bot = mem[p2];
            end
        end
    end

    assign bus.o_win_valid  = win_valid;
    assign bus.o_win_row    = win_row;
    assign bus.o_frame_done = frame_done;
    assign bus.o_overflow   = overflow;
    assign bus.o_cfg_err    = cfg_err;

    always_ff @(posedge s_clk) begin
        if (wr_en && !bus.code_valid) begin
            mem[wr_ptr] <= bus.i_line_data;
        end
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            wr_ptr     <= '0;
            fr_ptr     <= '0;
            occ        <= '0;
            rows_q     <= '0;
            lines_in   <= '0;
            win_row    <= '0;
            active     <= 1'b0;
            cfg_err    <= 1'b0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (bus.code_valid) begin
                wr_ptr   <= '0;
                fr_ptr   <= '0;
                occ      <= '0;
                lines_in <= '0;
                win_row  <= '0;
                rows_q   <= bus.i_rows;
                overflow <= 1'b0;
                cfg_err  <= (bus.i_rows < MIN_ROWS);
                active   <= (bus.i_rows >= MIN_ROWS);
            end else begin
                if (drop) begin
                    overflow <= 1'b1;
                end
                if (hs && last) begin
                    // Frame complete: flush and ignore lines until reconfigured.
                    wr_ptr     <= '0;
                    fr_ptr     <= '0;
                    occ        <= '0;
                    win_row    <= '0;
                    active     <= 1'b0;
                    frame_done <= 1'b1;
                end else begin
                    if (wr_en) begin
                        wr_ptr   <= inc(wr_ptr);
                        lines_in <= lines_in + 16'd1;
                    end
                    if (free) begin
                        fr_ptr <= p1;
                    end
                    if (hs) begin
                        win_row <= win_row + 16'd1;
                    end
                    occ <= occ + OW'(wr_en) - OW'(free);
                end
            end
        end
    end
endmodule

// File: doc/spike_line_window_buffer.md
SPIKE_LINE_WINDOW_BUFFER -- requirements
Module: spike_line_window_buffer

Interface
REQ-001 Parameter IMG_WIDTH, default 32: spike columns per line.
REQ-002 Parameter TIME_STEPS, default 4: spike bits per column.
REQ-003 Parameter DEPTH, default 4: line slots in buffer, minimum 4.
REQ-004 s_clk  input  1  clock; all state on rising edge.
REQ-005 s_rst  input  1  reset, asynchronous, active-high.
REQ-006 code_valid  input  1  configuration strobe; starts a new frame.
REQ-007 i_rows  input  16  frame line count, sampled on code_valid.
REQ-008 i_line_valid  input  1  one-cycle line strobe from the spike line organizer; no backpressure.
REQ-009 i_line_data  input  IMG_WIDTH*TIME_STEPS  packed line; column k occupies bits [(k+1)*TIME_STEPS-1 : k*TIME_STEPS].
REQ-010 o_win_valid  output  1  window available.
REQ-011 i_win_ready  input  1  consumer accepts the window.
REQ-012 o_win_top, o_win_mid, o_win_bot  output  IMG_WIDTH*TIME_STEPS each  three vertically adjacent lines.
REQ-013 o_win_row  output  16  output row index of the current window.
REQ-014 o_frame_done  output  1  one-cycle pulse after the last window handshake.
REQ-015 o_overflow  output  1  sticky: a line was dropped.
REQ-016 o_cfg_err  output  1  sticky: i_rows < 3 was sampled.

Function
REQ-017 Storage: DEPTH-slot circular line buffer; write pointer, free pointer and occupancy counter each wrap at DEPTH.
REQ-018 Write: i_line_valid with occupancy < DEPTH stores i_line_data at the write pointer; the pointer advances and occupancy increments.
REQ-019 Overflow: i_line_valid with occupancy == DEPTH drops the line, leaves pointers unchanged, and sets o_overflow.
REQ-020 Handshake: a window transfers on a cycle with o_win_valid && i_win_ready.
REQ-021 Hold: while o_win_valid=1 and i_win_ready=0, o_win_top, o_win_mid, o_win_bot and o_win_row are held stable.
REQ-022 Window r, without padding: {L(r), L(r+1), L(r+2)}, for r = 0 .. i_rows-3.
REQ-023 Window availability: o_win_valid rises on the cycle after the write of L(r+2), giving one cycle of latency.
REQ-024 Slot release: a handshake on window r frees L(r) (occupancy decrements); a write and a free in the same cycle leave occupancy unchanged.
REQ-025 Back-to-back transfer: with i_win_ready held high and lines already present, windows transfer on consecutive cycles.
REQ-026 Frame end: the handshake on the last window pulses o_frame_done on the next cycle, flushes all slots (occupancy=0, pointers=0) and clears o_win_row.
REQ-027 Lines beyond i_rows in a frame are ignored until the next code_valid.
REQ-028 code_valid mid-frame: all pointers, occupancy and o_win_row clear and o_win_valid drops on the next cycle; o_overflow and o_cfg_err clear; a new frame starts.
REQ-029 Config error: i_rows < 3 sets o_cfg_err; the block then produces no windows and ignores lines.

Reset
REQ-030 s_rst forces o_win_valid=0, o_frame_done=0, o_overflow=0, o_cfg_err=0 and o_win_row=0.
REQ-031 s_rst clears all pointers, occupancy and the sampled row count, and zeros all window data outputs; reset mid-frame discards the frame.

Configuration
REQ-032 Macro SPK_LINE_PAD_EN selects padding mode.
REQ-033 With SPK_LINE_PAD_EN defined:
- i_rows windows are produced.
- Window 0 = {0, L0, L1}, valid after the write of L1; its handshake frees no slot.
- Window r for 1 <= r <= i_rows-2 = {L(r-1), L(r), L(r+1)}; its handshake frees L(r-1).
- Window i_rows-1 = {L(i_rows-2), L(i_rows-1), 0}, valid the cycle after window i_rows-2 transfers.
- i_rows >= 2 is legal.
REQ-034 Without SPK_LINE_PAD_EN: REQ-022 behaviour applies, with i_rows-2 windows per frame and no zero lines.

Verification
REQ-035 i_rows=5, no pad, i_win_ready=1, lines L0..L4 one per 4 cycles -> 3 windows with o_win_row 0,1,2; o_win_valid rises 1 cycle after L2, L3 and L4; o_frame_done pulses once.
REQ-036 i_rows=8, i_win_ready=0, 5 lines sent -> fifth line dropped, o_overflow=1, o_win_valid=1 holding {L0, L1, L2} stable.
REQ-037 Simultaneous line write and window handshake at occupancy 4 (DEPTH=4) -> write accepted, occupancy stays 4, no overflow.
REQ-038 SPK_LINE_PAD_EN, i_rows=3 -> windows {0, L0, L1}, {L0, L1, L2}, {L1, L2, 0}, then o_frame_done.
REQ-039 code_valid asserted after 2 of 5 lines, then i_rows=4 -> o_win_valid stays 0; new frame yields 2 windows from fresh lines only; s_rst mid-frame -> all outputs 0.
REQ-040 i_rows=2 without pad -> o_cfg_err=1, no window for any line input.
